dot_product_serial_driver: RTL and testbench
============================================

# dot_product_serial_driver

Host-side initiator for the serial dot-product engine. It accepts two 64-bit vectors over a parallel valid/ready handshake and pulses `Start`. It then shifts vector A and vector B LSB-first onto `SerialData`, waits for the engine's `Done`, and returns the engine's 19-bit `DataOut` as a held result with a timeout flag. It sits between a bus-side producer (testbench or CPU register block) and the dot-product engine, driving that engine's `Start`/`SerialData` inputs and monitoring its `Done`/`DataOut` outputs.

## Interface
- `TIMEOUT`, default 16: cycles allowed in WAIT_DONE before declaring error; legal range 1..255.
- `clk`  input  1  clock; all logic on rising edge.
- `Reset`  input  1  asynchronous, active-high.
- `req_valid`  input  1  producer has vectors on `vec_a`/`vec_b`.
- `req_ready`  output  1  driver can accept a request; high only in IDLE.
- `vec_a`  input  64  vector A; byte k is element k, unsigned.
- `vec_b`  input  64  vector B; same layout.
- `Start`  output  1  one-cycle start pulse to the engine.
- `SerialData`  output  1  serial bit stream to the engine.
- `DataOut`  input  19  engine result; valid in the cycle `Done` is high.
- `Done`  input  1  engine completion pulse.
- `result`  output  19  captured dot product.
- `result_valid`  output  1  `result`/`timeout_err` valid; held until consumed.
- `result_ready`  input  1  consumer accepts the result.
- `timeout_err`  output  1  set with `result_valid` when `Done` never arrived.

## Operation
- States: IDLE, START, SEND_A, SEND_B, WAIT_DONE, RESULT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `vec_a`/`vec_b` into a 128-bit shift register {B,A} and go to START.
- START:
  - `Start`=1 for exactly this cycle.
  - Load bit counter to 63; go to SEND_A.
- SEND_A:
  - `SerialData`=shift[0]; shift right by one each cycle.
  - Counter decrements. At counter 0, reload to 63 and go to SEND_B.
  - Exactly 64 cycles; A[0] first, A[63] last.
- SEND_B:
  - Same as SEND_A, for B[0]..B[63], 64 cycles.
  - Then clear the timeout counter and go to WAIT_DONE.
- WAIT_DONE:
  - `SerialData`=0. The timeout counter increments each cycle.
  - On `Done`=1, capture `DataOut` into `result`, clear `timeout_err`, and go to RESULT.
  - If the counter reaches `TIMEOUT` with no `Done`, set `result`=0 and `timeout_err`=1, then go to RESULT.
  - `Done` and timeout in the same cycle: `Done` wins.
- RESULT:
  - `result_valid`=1; `result`/`timeout_err` held stable.
  - On `result_ready`=1, go to IDLE.
  - `req_ready` stays 0 here, so no new request overlaps.
- `Done` seen outside WAIT_DONE is ignored and does not alter `result`.
- `req_valid` outside IDLE is ignored; the producer holds its request until `req_ready`.
- Latched vectors are frozen during transmission; changes on `vec_a`/`vec_b` after acceptance have no effect.
- `DataOut` is captured verbatim at 19 bits. No arithmetic in the driver; the maximum legal value is 8*255*255 = 520200.

## Timing
- Reset values:
  - State IDLE; `req_ready`=1.
  - `Start`=0, `SerialData`=0.
  - `result`=0, `result_valid`=0, `timeout_err`=0.
  - Counters 0; shift register 0.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronously). The partial frame is abandoned and no result is produced.
- All outputs are registered (no combinational input-to-output path). Exception: `req_ready` may be decoded from the state register.
- Let acceptance occur at edge t (`req_valid`&&`req_ready` sampled).
  - `Start`=1 during cycle t+1.
  - A[i] drives `SerialData` during cycle t+2+i, for i=0..63.
  - B[i] drives `SerialData` during cycle t+66+i, for i=0..63.
  - WAIT_DONE starts at cycle t+130.
- The nominal engine asserts `Done` during cycle t+135, which is within the default `TIMEOUT`. `result_valid` then rises in cycle t+136.
- Timeout path, no `Done`: `result_valid` rises TIMEOUT+1 cycles after WAIT_DONE entry.
- Throughput: one request per 137 cycles minimum, when `result_ready` is held high and `req_valid` is held high.

## Test plan
- Connected to the dot-product engine, A=0x0807060504030201, B=0x0101010101010101: `result`=36 (0x24), `timeout_err`=0, and `result_valid` in cycle t+136.
- A=B=0xFFFFFFFFFFFFFFFF: `result`=520200. On `SerialData`, check 64 ones after `Start` for A, then 64 ones for B.
- `Done` held low by a stub engine with `TIMEOUT`=16: `result_valid`=1 with `timeout_err`=1 and `result`=0, 17 cycles after WAIT_DONE entry.
- Bit-level check with a stub: A=0x1, B=0x8000000000000000.
  - Required stream: 1 then 63 zeros, then 63 zeros then 1.
  - A spurious `Done` pulse during SEND_A is ignored.
- Back-to-back: two requests with `result_ready` held low for 10 cycles after the first result.
  - `req_ready`=0 throughout that window and the first result holds stable.
  - The second `Start` occurs 2 cycles after `result_ready` is asserted.
- `Reset` asserted at bit 30 of SEND_B: `Start`, `SerialData` and `result_valid` go to 0. The next request then completes with the correct result.

Source files
------------

// File: rtl/dot_product_serial_driver.sv
// Host-side initiator for the serial dot-product engine: accepts two 64-bit vectors,
// streams them LSB-first after a Start pulse, and returns the engine result or a timeout.
module dot_product_serial_driver #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] vec_a,
  input  logic [63:0] vec_b,
  output logic        Start,
  output logic        SerialData,
  input  logic [18:0] DataOut,
  input  logic        Done,
  output logic [18:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        timeout_err
);

  localparam int unsigned VecW    = 64;
  localparam int unsigned ShiftW  = 2 * VecW;
  localparam int unsigned ResW    = 19;
  localparam int unsigned BitCntW = 6;
  localparam int unsigned ToCntW  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_DONE,
    S_RESULT
  } state_e;

  state_e              state_q, state_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [ToCntW-1:0]   to_cnt_q, to_cnt_d;
  logic                start_q, start_d;
  logic                serial_q, serial_d;
  logic [ResW-1:0]     result_q, result_d;
  logic                result_valid_q, result_valid_d;
  logic                timeout_err_q, timeout_err_d;

  // State and registered outputs; everything clears asynchronously on Reset.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      to_cnt_q       <= '0;
      start_q        <= 1'b0;
      serial_q       <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      to_cnt_q       <= to_cnt_d;
      start_q        <= start_d;
      serial_q       <= serial_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Next state; serial_d always carries the bit for the following cycle, so the
  // shift register runs one bit ahead of SerialData.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    to_cnt_d       = to_cnt_q;
    start_d        = 1'b0;
    serial_d       = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          shift_d = {vec_b, vec_a};
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        bit_cnt_d = BitCntW'(63);
        serial_d  = shift_q[0];
        shift_d   = shift_q >> 1;
        state_d   = S_SEND_A;
      end
      S_SEND_A: begin
        serial_d = shift_q[0];
        shift_d  = shift_q >> 1;
        if (bit_cnt_q == '0) begin
          bit_cnt_d = BitCntW'(63);
          state_d   = S_SEND_B;
        end else begin
          bit_cnt_d = bit_cnt_q - BitCntW'(1);
        end
      end
      S_SEND_B: begin
        if (bit_cnt_q == '0) begin
          to_cnt_d = '0;
          state_d  = S_WAIT_DONE;
        end else begin
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q - BitCntW'(1);
        end
      end
      S_WAIT_DONE: begin
        to_cnt_d = to_cnt_q + ToCntW'(1);
        if (Done) begin
          result_d       = DataOut;
          timeout_err_d  = 1'b0;
          result_valid_d = 1'b1;
          state_d        = S_RESULT;
        end else if (to_cnt_q == ToCntW'(TIMEOUT)) begin
          result_d       = '0;
          timeout_err_d  = 1'b1;
          result_valid_d = 1'b1;
          state_d        = S_RESULT;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready    = (state_q == S_IDLE);
  assign Start        = start_q;
  assign SerialData   = serial_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_dot_product_serial_driver.sv
// Scoreboard bench for dot_product_serial_driver with a behavioural engine that
// deserialises the stream and answers with the dot product (or stays silent).
module tb_dot_product_serial_driver;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        Reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] vec_a, vec_b;
  logic        Start;
  logic        SerialData;
  logic [18:0] DataOut;
  logic        Done;
  logic [18:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        timeout_err;

  dot_product_serial_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .vec_a(vec_a), .vec_b(vec_b),
    .Start(Start), .SerialData(SerialData),
    .DataOut(DataOut), .Done(Done),
    .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int eng_mode  = 0;           // 0 engine, 1 silent, 2 engine plus spurious Done
  logic [127:0] eng_bits;
  logic [19:0]  exp_q[$];      // {timeout_err, result}

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (Start) start_cyc = cyc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] dot(input logic [63:0] a, input logic [63:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) s += int'(a[8*k +: 8]) * int'(b[8*k +: 8]);
    return 19'(s);
  endfunction

  // Engine model: sample 128 bits after Start, answer 6 cycles after the last bit.
  initial begin : engine
    logic abort;
    Done = 1'b0;
    DataOut = '0;
    forever begin
      @(negedge clk);
      if (Start && !Reset) begin
        abort = 1'b0;
        for (int i = 0; i < 128 && !abort; i++) begin
          @(negedge clk);
          if (Reset) abort = 1'b1;
          else eng_bits[i] = SerialData;
          if (eng_mode == 2 && i == 10) begin
            Done = 1'b1;
            DataOut = '1;
          end else begin
            Done = 1'b0;
            DataOut = '0;
          end
        end
        Done = 1'b0;
        if (!abort) begin
          repeat (6) @(negedge clk);
          if (eng_mode != 1) begin
            Done = 1'b1;
            DataOut = dot(eng_bits[63:0], eng_bits[127:64]);
            @(negedge clk);
            Done = 1'b0;
            DataOut = '0;
          end
        end
      end
    end
  end

  task automatic send_req(input logic [63:0] a, input logic [63:0] b, input logic [19:0] exp);
    bit got;
    got = 1'b0;
    @(negedge clk);
    vec_a = a;
    vec_b = b;
    req_valid = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("accept_timeout", 0, 1);
    exp_q.push_back(exp);
    @(negedge clk);
    req_valid = 1'b0;
    vec_a = ~a;
    vec_b = ~b;
    check("start_after_accept", Start, 1);
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    logic [19:0] e;
    for (int k = 0; k < 400 && !result_valid; k++) @(negedge clk);
    if (!result_valid) check({tag, "_no_result"}, 0, 1);
    else if (exp_q.size() == 0) check({tag, "_sb_empty"}, 0, 1);
    else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, result, e[18:0]);
      check({tag, "_terr"}, timeout_err, e[19]);
      check({tag, "_latency"}, cyc - start_cyc, exp_lat);
    end
  endtask

  task automatic consume();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [63:0] a, b, a2, b2;
    logic [18:0] held;
    logic        bad;
    int          rr_cyc;
    bit          seen;

    Reset = 1'b1;
    req_valid = 1'b0;
    vec_a = '0;
    vec_b = '0;
    result_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_start", Start, 0);
    check("rst_serial", SerialData, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    Reset = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal transfer through the engine model
    a = 64'h0807060504030201;
    b = 64'h0101010101010101;
    send_req(a, b, {1'b0, 19'd36});
    wait_result("nominal", 135);
    check("nominal_stream", eng_bits, {b, a});
    consume();

    // Maximum operands
    a = '1;
    b = '1;
    send_req(a, b, {1'b0, 19'd520200});
    wait_result("max", 135);
    check("max_stream_a", eng_bits[63:0], a);
    check("max_stream_b", eng_bits[127:64], b);
    consume();

    // Silent engine: timeout path
    eng_mode = 1;
    send_req(64'h1234, 64'h5678, {1'b1, 19'd0});
    wait_result("timeout", 129 + TO + 1);
    consume();

    // Bit-level stream with a spurious Done during SEND_A
    eng_mode = 2;
    a = 64'h1;
    b = 64'h8000000000000000;
    send_req(a, b, {1'b0, dot(a, b)});
    repeat (20) @(negedge clk);
    check("spur_result", result, 0);
    check("spur_result_valid", result_valid, 0);
    wait_result("spur", 135);
    check("spur_stream", eng_bits, {b, a});
    consume();
    eng_mode = 0;

    // Back-to-back with a stalled consumer
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {$urandom, $urandom};
    @(negedge clk);
    vec_a = a;
    vec_b = b;
    req_valid = 1'b1;
    check("b2b_ready", req_ready, 1);
    exp_q.push_back({1'b0, dot(a, b)});
    @(negedge clk);
    vec_a = a2;
    vec_b = b2;
    exp_q.push_back({1'b0, dot(a2, b2)});
    wait_result("b2b_first", 135);
    held = result;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready || !result_valid || result !== held) bad = 1'b1;
    end
    check("b2b_hold", bad, 0);
    result_ready = 1'b1;
    rr_cyc = cyc;
    @(negedge clk);
    result_ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (Start) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_start_gap", seen ? cyc - rr_cyc : -1, 2);
    req_valid = 1'b0;
    vec_a = ~a2;
    vec_b = ~b2;
    wait_result("b2b_second", 135);
    consume();

    // Reset during SEND_B bit 30, then a clean transfer
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    b[30] = 1'b1;
    send_req(a, b, {1'b0, dot(a, b)});
    for (int k = 0; k < 200 && cyc != start_cyc + 95; k++) @(negedge clk);
    check("rst_mid_bit30", SerialData, b[30]);
    Reset = 1'b1;
    #1;
    check("rst_mid_start", Start, 0);
    check("rst_mid_serial", SerialData, 0);
    check("rst_mid_result_valid", result_valid, 0);
    check("rst_mid_req_ready", req_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    a = 64'h0102030405060708;
    b = 64'h1122334455667788;
    send_req(a, b, {1'b0, dot(a, b)});
    wait_result("post_reset", 135);
    consume();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
